// File: rtl/rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkt_fifo
// Purpose  : Packetising receive FIFO placed directly after the UART receiver.
//            Each received byte is parked in a one-entry staging register
//            until the next event shows whether it ends a packet. A second
//            byte pushes it with last=0; an end-of-packet strobe pushes it
//            with last=1. Entries go into a flop-based first-word-fall-through
//            FIFO whose head is presented on out_*.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid/in_data    - one-cycle byte strobe and byte
//            in_eop              - one-cycle end-of-packet strobe
//            out_valid/out_data/out_last/out_ready - FWFT head handshake
//            level               - FIFO occupancy (staging register excluded)
//            pkt_avail           - at least one complete packet is buffered
//            overflow/ovf_clr    - sticky drop flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module rx_pkt_fifo #(
  parameter int DEPTH = 16,
  // Derived pointer width; must stay at its default.
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_eop,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          pkt_avail,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

  // Storage: {last, byte}
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [AW:0]   r_pkt_cnt;
  logic [7:0]    r_stage_data;
  logic          r_stage_full;
  logic          r_overflow;

  logic          w_push;
  logic          w_push_last;
  logic          w_pop;
  logic          w_full;
  logic          w_push_ok;
  logic          w_drop;
  logic          w_pkt_inc;
  logic          w_pkt_dec;

  // A push only ever drains the staging register, so it needs a full stage
  // plus either a new byte (evicts it) or an end-of-packet (terminates it).
  // An eop arriving with an empty stage is deliberately ignored.
  assign w_push      = r_stage_full & (in_valid | in_eop);
  assign w_push_last = in_eop;

  assign out_valid   = (r_level != '0);
  assign w_pop       = out_valid & out_ready;
  assign w_full      = (r_level == c_full_level);

  // A simultaneous pop frees the slot the push needs, so a full FIFO still
  // accepts the entry in that case.
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;

  assign out_data    = r_mem[r_rd_ptr][7:0];
  // Masked with out_valid so stale memory never shows last=1 when empty.
  assign out_last    = out_valid & r_mem[r_rd_ptr][8];

  assign w_pkt_inc   = w_push_ok & w_push_last;
  assign w_pkt_dec   = w_pop & out_last;

  assign level       = r_level;
  assign pkt_avail   = (r_pkt_cnt != '0);
  assign overflow    = r_overflow;

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {w_push_last, r_stage_data};
    end
  end

  // Staging register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_data <= '0;
      r_stage_full <= 1'b0;
    end else if (in_valid) begin
      r_stage_data <= in_data;
      r_stage_full <= 1'b1;
    end else if (in_eop) begin
      r_stage_full <= 1'b0;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Complete-packet counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_pkt_fifo
// Purpose  : Self-checking bench for rx_pkt_fifo. A reference model at the
//            posedge turns the input strobes into expected FIFO entries held
//            in a queue; a negedge monitor compares DUT status against the
//            queue and pops/compares the head on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_pkt_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_eop;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_ready;
  logic [AW:0]   level;
  logic          pkt_avail;
  logic          overflow;
  logic          ovf_clr;

  rx_pkt_fifo #(.DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .level     (level),
    .pkt_avail (pkt_avail),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // exp_q holds the entries the FIFO should contain, oldest first: {last, byte}
  logic [8:0] exp_q[$];
  logic [7:0] m_stage_data;
  bit         m_stage_full;
  bit         m_ovf;
  bit         m_drop;

  function automatic int count_last();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][8]) n++;
    return n;
  endfunction

  // The monitor has already removed the entry popped at this edge, so a
  // queue of DEPTH entries here means full with no pop: the entry is lost.
  function automatic void model_push(logic [8:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else m_drop = 1'b1;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_stage_full = 1'b0;
    m_ovf        = 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      m_drop = 1'b0;
      if (in_valid) begin
        if (m_stage_full) model_push({in_eop, m_stage_data});
        m_stage_data = in_data;
        m_stage_full = 1'b1;
      end else if (in_eop && m_stage_full) begin
        model_push({1'b1, m_stage_data});
        m_stage_full = 1'b0;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] head;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("level", 32'(level), 32'(exp_q.size()));
    check("pkt_avail", 32'(pkt_avail), 32'(count_last() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() == 0) begin
      check("out_last_idle", 32'(out_last), 32'd0);
    end else if (out_ready && rst_n) begin
      head = exp_q.pop_front();
      check("out_data", 32'(out_data), 32'(head[7:0]));
      check("out_last", 32'(out_last), 32'(head[8]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic v, input logic [7:0] d, input logic e);
    in_valid = v;
    in_data  = d;
    in_eop   = e;
    tick();
    in_valid = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    idle(DEPTH + 4);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_eop    = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Spaced bytes, eop, consumer always ready
    out_ready = 1'b1;
    send(1'b1, 8'h41, 1'b0); idle(99);
    send(1'b1, 8'h42, 1'b0); idle(99);
    send(1'b1, 8'h43, 1'b0); idle(99);
    send(1'b0, 8'h00, 1'b1); idle(5);

    // Two packets stored, then drained
    out_ready = 1'b0;
    send(1'b1, 8'hA0, 1'b0); send(1'b1, 8'hA1, 1'b0); send(1'b0, 8'h00, 1'b1);
    send(1'b1, 8'hB0, 1'b0); send(1'b1, 8'hB1, 1'b0); send(1'b1, 8'hB2, 1'b0);
    send(1'b0, 8'h00, 1'b1); idle(3);
    check("two_pkt_level", 32'(level), 32'd5);
    drain();

    // Byte and eop together while staged, then a lone eop
    send(1'b1, 8'h10, 1'b0); idle(3);
    send(1'b1, 8'h20, 1'b1); idle(3);
    send(1'b0, 8'h00, 1'b1); idle(3);
    // eop with empty stage is ignored
    send(1'b0, 8'h00, 1'b1); idle(3);

    // Overflow: 18 bytes then eop with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) send(1'b1, 8'(8'h60 + i), 1'b0);
    send(1'b0, 8'h00, 1'b1); idle(2);
    check("ovf_level", 32'(level), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(out_data), 32'h60);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; idle(2);
    drain();

    // Full FIFO with simultaneous push and pop across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(1'b1, 8'(8'h80 + i), 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(1'b1, 8'(8'hC0 + i), 1'b0);
    send(1'b0, 8'h00, 1'b1);
    drain();

    // Reset mid-packet with level 3 and a full stage
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h30 + i), 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_pkt_avail", 32'(pkt_avail), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    out_ready = 1'b1;
    send(1'b1, 8'h5A, 1'b0); idle(2);
    send(1'b0, 8'h00, 1'b1); idle(4);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 99) < 45);
      ovf_clr   = ($urandom_range(0, 99) < 3);
      send(($urandom_range(0, 99) < 40), 8'($urandom), ($urandom_range(0, 99) < 12));
      ovf_clr   = 1'b0;
    end
    send(1'b0, 8'h00, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_pkt_fifo.md
Name: rx_pkt_fifo

Overview:
- Sits directly downstream of the UART receiver in the rx pipe.
- Consumes the receiver's one-cycle byte strobe (rx_ready/rx_data) and end-of-packet strobe (rx_eop).
- Buffers bytes in a flop-based first-word-fall-through FIFO, tagging the final byte of each packet with a last flag.
- rx_eop arrives only after the line has idled, so the most recent byte is held in a one-entry staging register until its last-ness is known.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, >= 2.
- AW, $clog2(DEPTH), derived pointer width; not to be overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  byte strobe, one cycle (driven by rx_ready)
- in_data  input  8  byte, valid when in_valid=1
- in_eop  input  1  end-of-packet strobe, one cycle (driven by rx_eop)
- out_valid  output  1  head entry present
- out_data  output  8  head byte
- out_last  output  1  head byte ends a packet
- out_ready  input  1  consumer accepts head when out_valid=1
- level  output  AW+1  FIFO occupancy, staging register excluded
- pkt_avail  output  1  at least one complete packet (an entry with last=1) in FIFO
- overflow  output  1  sticky: a byte was dropped
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (async assert, sync deassert by caller): pointers=0, level=0, staging empty, pkt count=0, out_valid=0, out_last=0, overflow=0. out_data is don't-care while out_valid=0.
- Staging register holds {byte, full flag}. At most one FIFO push per cycle.
- Cycle events, evaluated on the same clock edge:
  - in_valid=1, stage empty: byte into stage; no push.
  - in_valid=1, stage full, in_eop=0: push {stage, last=0}; new byte into stage.
  - in_eop=1, stage full, in_valid=0: push {stage, last=1}; stage empty.
  - in_valid=1 and in_eop=1, stage full: push {stage, last=1}; new byte into stage.
  - in_eop=1, stage empty: ignored, no push, no state change. This covers the case where the new byte lands in an empty stage in the same cycle.
- Pop: out_valid && out_ready. Head advances on the next edge.
- out_valid = (level != 0). out_data and out_last read combinationally from the head entry.
- Latency: a pushed entry is visible on out_* the cycle after the push edge.
- Push while level==DEPTH:
  - With a pop the same cycle: both occur, level unchanged.
  - Without a pop: entry dropped, overflow<=1, pointers unchanged. Any earlier partial packet remains unterminated; this is accepted.
- overflow: set has priority over ovf_clr in the same cycle. Otherwise ovf_clr=1 clears it.
- Pop while level==0: impossible by handshake; no state change.
- Pointers are AW bits and wrap modulo DEPTH.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..DEPTH.
- Packet counter (AW+1 bits): +1 on a push with last=1, -1 on a pop with out_last=1, both in the same cycle leaves it unchanged. pkt_avail = counter != 0.
- No output depends combinationally on in_* signals.

Test Plan:
- Bytes 0x41,0x42,0x43 at 100-cycle spacing, then in_eop; out_ready=1 -> out entries 0x41/last0, 0x42/last0, 0x43/last1. 0x43 appears one cycle after the in_eop edge. pkt_avail pulses high for one cycle.
- out_ready=0; packet A (2 bytes) + eop, then packet B (3 bytes) + eop -> level=5 and pkt_avail=1. Drain: out_last=1 on the 2nd and 5th pops. pkt_avail drops after the 5th pop.
- in_valid and in_eop together while stage holds 0x10, new byte 0x20; later a lone eop -> entries 0x10/last1, then 0x20/last1.
- DEPTH=16, out_ready=0, 18 bytes then eop -> level=16, overflow=1. Head = first byte. 17th byte dropped; the pushed 18th (last1) is also dropped. Pulse ovf_clr -> overflow=0.
- FIFO full, push and pop in the same cycle -> level stays 16, overflow stays 0, data order preserved across pointer wrap.
- rst_n low mid-packet with level=3 and stage full -> immediately out_valid=0, level=0, pkt_avail=0. After release, a fresh 1-byte packet emerges alone with last=1.
